slt_serial_unit: RTL and testbench
==================================

Name: slt_serial_unit

Overview:
- Multi-cycle set-less-than engine; the sequential responder counterpart to the combinational SLTI datapath.
- Accepts an operand pair over a valid/ready request channel.
- Resolves signed or unsigned "A < B" by scanning fixed-width chunks from MSB to LSB.
- Returns a zero-extended 0/1 result over a valid/ready response channel.
- Sits beside the ALU in the EX stage for SLT/SLTU/SLTI/SLTIU when the area-reduced compare option is selected.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- BITS_PER_CYCLE, 4, bits compared per SCAN cycle. DATA_WIDTH % BITS_PER_CYCLE must be 0; otherwise elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request ready; high only in IDLE.
- SrcA  input  DATA_WIDTH  rs1 value.
- SrcB  input  DATA_WIDTH  rs2 value or sign-extended immediate.
- is_unsigned  input  1  1 = SLTU/SLTIU compare, 0 = signed compare.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Rd  output  DATA_WIDTH  result, 0 or 1, zero-extended.

Behaviour:
- NCH = DATA_WIDTH/BITS_PER_CYCLE. Chunk 0 is the MSB chunk.
- Reset (async, any state, including mid-SCAN): state = IDLE, out_valid = 0, Rd = 0, chunk index = 0, operand registers = 0. in_ready = 1 while in reset, since it decodes state == IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready, capture operands into A_r and B_r, index = 0, go to SCAN.
  - Signed capture: the MSB of both operands is inverted (A ^ 1<<(DATA_WIDTH-1), same for B). Signed compare then reduces to unsigned compare.
  - Unsigned capture: no inversion.
- SCAN:
  - Each cycle, compare chunk[index] of A_r vs B_r, unsigned.
  - If the chunks differ, latch lt = (A chunk < B chunk) and mark decided.
  - Exit to DONE after processing the last chunk, or earlier per the optional feature.
  - If no chunk ever differs, lt = 0 (equal operands give Rd = 0).
  - in_ready = 0. in_valid is ignored.
- DONE:
  - out_valid = 1, Rd = {DATA_WIDTH-1 zeros, lt}.
  - Rd and out_valid hold stable while out_ready = 0.
  - On an edge with out_valid && out_ready, clear out_valid and go to IDLE. Rd keeps its last value.
  - No new request is accepted in the same edge; minimum issue interval is latency + 2 cycles.
- Latency: out_valid rises N edges after the acceptance edge. N = NCH, or less under early exit.
- The first differing chunk wins; later chunks cannot change lt.
- in_valid asserted outside IDLE has no effect. The source must hold its request until in_ready.
- A reset pulse in DONE drops out_valid asynchronously; the pending result is lost.

Optional Feature:
- Macro: SLT_EARLY_EXIT_EN.
- Defined: SCAN moves to DONE on the edge that processes the first differing chunk, so N = index_of_first_differing_chunk + 1. Equal operands still take N = NCH.
- Undefined: fixed latency N = NCH for every request. lt is still taken from the first differing chunk. Gives deterministic pipeline timing.

Test Plan:
- Signed, SrcA=0x00000005, SrcB=0x0000000A -> Rd=0x00000001, N=8 in both builds (difference is in chunk 7).
- Signed, SrcA=0x0000000F, SrcB=0x0000000A -> Rd=0x00000000, N=8.
- Signed, SrcA=0xFFFFFFFB, SrcB=0x00000003 -> Rd=0x00000001; N=1 with SLT_EARLY_EXIT_EN, N=8 without.
- Unsigned, SrcA=0xFFFFFFFB, SrcB=0x00000003 -> Rd=0x00000000, N=1 (early exit). Unsigned, SrcA=0x00100000, SrcB=0x00200000 -> Rd=1, N=3 (early exit).
- Equal operands 0x80000000/0x80000000, signed -> Rd=0, N=8. Hold out_ready=0 for 3 cycles -> out_valid and Rd stable. in_ready=0 until the cycle after the response handshake.
- Assert reset for 1 cycle mid-SCAN (index 3) -> out_valid=0, Rd=0, in_ready=1 immediately. A new request afterwards (signed, SrcA=-1, SrcB=0) -> Rd=1 with correct latency.

Source files
------------

// File: rtl/slt_serial_unit.sv
// Multi-cycle set-less-than engine: scans operand chunks MSB-first over valid/ready.
// Optional SLT_EARLY_EXIT_EN: finish on the first differing chunk instead of after all chunks.
module slt_serial_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  is_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Rd
);

    localparam int NCH = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);
    localparam logic [DATA_WIDTH-1:0] SIGN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (DATA_WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    lt_q, lt_d;
    logic                    dec_q, dec_d;
    logic                    rd_q, rd_d;

    logic [BITS_PER_CYCLE-1:0] ca, cb;
    logic                      differ;
    logic                      chunk_lt;
    logic                      lt_fin;
    logic                      exit_scan;

    // Operands shift left each SCAN cycle, so the current chunk is always on top.
    assign ca       = a_q[DATA_WIDTH-1 -: BITS_PER_CYCLE];
    assign cb       = b_q[DATA_WIDTH-1 -: BITS_PER_CYCLE];
    assign differ   = (ca != cb);
    assign chunk_lt = (ca < cb);
    assign lt_fin   = dec_q ? lt_q : (differ & chunk_lt);

`ifdef SLT_EARLY_EXIT_EN
    assign exit_scan = (idx_q == LAST) | differ;
`else
    assign exit_scan = (idx_q == LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = SCAN;
            SCAN: if (exit_scan) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        Rd        = {{(DATA_WIDTH-1){1'b0}}, rd_q};
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        idx_d = idx_q;
        lt_d  = lt_q;
        dec_d = dec_q;
        rd_d  = rd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Biasing the sign bit turns a signed compare into an unsigned one.
                    a_d   = is_unsigned ? SrcA : (SrcA ^ SIGN);
                    b_d   = is_unsigned ? SrcB : (SrcB ^ SIGN);
                    idx_d = '0;
                    lt_d  = 1'b0;
                    dec_d = 1'b0;
                end
            end
            SCAN: begin
                a_d   = a_q << BITS_PER_CYCLE;
                b_d   = b_q << BITS_PER_CYCLE;
                idx_d = idx_q + 1'b1;
                if (differ && !dec_q) begin
                    dec_d = 1'b1;
                    lt_d  = chunk_lt;
                end
                if (exit_scan) begin
                    rd_d = lt_fin;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            lt_q  <= 1'b0;
            dec_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            idx_q <= idx_d;
            lt_q  <= lt_d;
            dec_q <= dec_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: tb/tb_slt_serial_unit.sv
// Scoreboard bench for slt_serial_unit: driver pushes expected results,
// monitor pops and checks result, latency and handshake behaviour.
module tb_slt_serial_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Rd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int issued = 0;
    int done_n = 0;

    typedef struct {
        logic [31:0] rd;
        int          n;
        int          acc;
        int          hold;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
        logic [31:0] rd;
        int          n_ee;
        int          hold;
    } vec_t;

    slt_serial_unit #(
        .DATA_WIDTH(32),
        .BITS_PER_CYCLE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .is_unsigned(is_unsigned),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Rd(Rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input int n_ee);
`ifdef SLT_EARLY_EXIT_EN
        return n_ee;
`else
        return 8 + 0 * n_ee;
`endif
    endfunction

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_in_ready: got timeout expected in_ready");
        end
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        wait_ready();
        SrcA        = v.a;
        SrcB        = v.b;
        is_unsigned = v.u;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        e.rd   = v.rd;
        e.n    = lat(v.n_ee);
        e.acc  = cyc;
        e.hold = v.hold;
        sb.push_back(e);
        issued++;
        in_valid = 1'b0;
        SrcA     = 32'hDEAD_BEEF;
        SrcB     = 32'h0;
        @(negedge clk);
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (done_n != issued && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_n != issued) begin
            errors++;
            $display("FAIL drain: got %0d responses expected %0d", done_n, issued);
        end
    endtask

    // Monitor: checks each response, then holds out_ready low for the requested cycles.
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got %h expected none", Rd);
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                end else begin
                    e = sb.pop_front();
                    chk("rd", Rd, e.rd);
                    chk("latency", 32'(cyc - e.acc), 32'(e.n));
                    chk("in_ready_done", {31'b0, in_ready}, 32'd0);
                    repeat (e.hold) begin
                        @(negedge clk);
                        chk("hold_valid", {31'b0, out_valid}, 32'd1);
                        chk("hold_rd", Rd, e.rd);
                        chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    chk("valid_cleared", {31'b0, out_valid}, 32'd0);
                    chk("in_ready_after", {31'b0, in_ready}, 32'd1);
                    chk("rd_kept", Rd, e.rd);
                    done_n++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    vec_t v;

    initial begin
        vecs[0] = '{32'h0000_0005, 32'h0000_000A, 1'b0, 32'd1, 8, 0};
        vecs[1] = '{32'h0000_000F, 32'h0000_000A, 1'b0, 32'd0, 8, 1};
        vecs[2] = '{32'hFFFF_FFFB, 32'h0000_0003, 1'b0, 32'd1, 1, 0};
        vecs[3] = '{32'hFFFF_FFFB, 32'h0000_0003, 1'b1, 32'd0, 1, 2};
        vecs[4] = '{32'h0000_0003, 32'hFFFF_FFFB, 1'b0, 32'd0, 1, 0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 8, 3};
        vecs[6] = '{32'h0010_0000, 32'h0020_0000, 1'b1, 32'd1, 3, 1};

        reset       = 1'b1;
        in_valid    = 1'b0;
        SrcA        = '0;
        SrcB        = '0;
        is_unsigned = 1'b0;
        #3;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_rd", Rd, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i]);
        end
        drain();
        chk("rd_before_abort", Rd, 32'd1);

        // Abort an equal-operand scan at chunk index 3.
        wait_ready();
        SrcA        = 32'h8000_0000;
        SrcB        = 32'h8000_0000;
        is_unsigned = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_rd", Rd, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        v = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'd1, 1, 1};
        issue(v);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
